// File: rtl/pwm_audio_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_audio_stream_gen
// Brief    : Multi-channel PWM audio generator. Signed samples are staged one
//            frame at a time, attenuated and converted to offset binary, then
//            loaded into per-channel duty registers at each PWM period
//            boundary. Starved boundaries raise a sticky underrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_audio_stream_gen #(
  parameter int SAMPLE_W = 8,
  parameter int PWM_W    = 8,
  parameter int NUM_CH   = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [3:0]                   volume,
  input  logic                         mute,
  input  logic                         clr_underrun,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic                         period_start,
  output logic                         underrun
);

  localparam logic [PWM_W-1:0] C_CNT_MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] C_CNT_ONE = PWM_W'(1);
  localparam logic [PWM_W-1:0] C_MID     = {1'b1, {(PWM_W-1){1'b0}}};

  logic [PWM_W-1:0]           r_cnt;
  logic [NUM_CH*SAMPLE_W-1:0] r_stage;
  logic                       r_full;
  logic                       r_ready;
  logic                       r_underrun;
  logic [NUM_CH-1:0]          r_pwm;
  logic                       r_period_start;

  logic                       w_wrap;
  logic                       w_accept;
  logic                       w_full_next;
  logic [NUM_CH-1:0]          w_cmp;

  // The last counter value of a period is the only place duties may change.
  assign w_wrap   = (r_cnt == C_CNT_MAX);
  // Ready is a pure register, so accepting never depends combinationally on valid.
  assign w_accept = sample_valid & r_ready;
  // Staging fills on accept and empties on the boundary that consumes it.
  // Accept and consume can never coincide because ready is low while full.
  assign w_full_next = w_accept | (r_full & ~w_wrap);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [SAMPLE_W-1:0] w_samp;
      logic signed [SAMPLE_W-1:0] w_shift;
      logic        [SAMPLE_W-1:0] w_ub;
      logic        [PWM_W-1:0]    w_scaled;
      logic        [PWM_W-1:0]    r_duty;

      assign w_samp  = r_stage[c*SAMPLE_W +: SAMPLE_W];
      // Arithmetic shift keeps the sign; large shifts saturate to 0 or -1.
      assign w_shift = w_samp >>> volume;
      // Flipping the sign bit converts two's complement to offset binary.
      assign w_ub    = {~w_shift[SAMPLE_W-1], w_shift[SAMPLE_W-2:0]};

      if (PWM_W == SAMPLE_W) begin : g_same
        assign w_scaled = w_ub;
      end else if (PWM_W > SAMPLE_W) begin : g_up
        assign w_scaled = {w_ub, {(PWM_W-SAMPLE_W){1'b0}}};
      end else begin : g_down
        assign w_scaled = w_ub[SAMPLE_W-1 -: PWM_W];
      end

      // Duty reloads only on the wrap cycle so a period is never truncated.
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          r_duty <= C_MID;
        end else if (w_wrap) begin
          if (mute) begin
            r_duty <= C_MID;
          end else if (r_full) begin
            r_duty <= w_scaled;
          end
        end
      end

      assign w_cmp[c] = (r_cnt < r_duty);
    end
  endgenerate

  // Counter, staging handshake, underrun tracking and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_cnt          <= '0;
      r_stage        <= '0;
      r_full         <= 1'b0;
      r_ready        <= 1'b0;
      r_underrun     <= 1'b0;
      r_pwm          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + C_CNT_ONE;
      if (w_accept) begin
        r_stage <= sample_in;
      end
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;
      // A starved boundary wins over a simultaneous clear request.
      r_underrun     <= (w_wrap & ~r_full) | (r_underrun & ~clr_underrun);
      r_pwm          <= w_cmp;
      r_period_start <= (r_cnt == '0);
    end
  end

  assign sample_ready = r_ready;
  assign underrun     = r_underrun;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_audio_stream_gen
// Brief    : Directed, table-driven bench for pwm_audio_stream_gen with
//            default parameters (8-bit samples, 8-bit PWM, two channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_audio_stream_gen;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  volume;
  logic        mute;
  logic        clr_underrun;
  logic [1:0]  pwm_out;
  logic        period_start;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vol;
    logic       mte;
    logic [7:0] s0;
    logic [7:0] s1;
    int         h0;
    int         h1;
  } vec_t;

  vec_t vecs[8];

  pwm_audio_stream_gen #(
    .SAMPLE_W(8),
    .PWM_W   (8),
    .NUM_CH  (2)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .volume      (volume),
    .mute        (mute),
    .clr_underrun(clr_underrun),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .underrun    (underrun)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  // Hard stop in case the bench itself loses its way.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns at the first negedge (including the current one) showing period_start.
  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (period_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge CLK);
    end
    check("period_start_timeout", 32'd0, 32'd1);
  endtask

  // Counts high cycles per channel over one full period starting at period_start.
  task automatic measure(input string tag, input int e0, input int e1);
    bit ok;
    int h0, h1, extra;
    h0 = 0; h1 = 0; extra = 0;
    wait_ps(ok);
    if (!ok) return;
    for (int i = 0; i < 256; i++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (i > 0 && period_start === 1'b1) extra++;
      if (i < 255) @(negedge CLK);
    end
    check({tag, "_ch0_high"}, h0, e0);
    check({tag, "_ch1_high"}, h1, e1);
    check({tag, "_ps_extra"}, extra, 0);
  endtask

  // Presents one frame for a single accepting edge.
  task automatic send(input logic [7:0] s0, input logic [7:0] s1);
    int n;
    n = 0;
    while (sample_ready !== 1'b1 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 600) begin
      check("send_ready_timeout", 32'd0, 32'd1);
      return;
    end
    sample_in    = {s1, s0};
    sample_valid = 1'b1;
    @(negedge CLK);
    sample_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int lows;

    vecs[0] = '{4'd0,  1'b0, 8'h7F, 8'h80, 255,   0};
    vecs[1] = '{4'd1,  1'b0, 8'h40, 8'h80, 160,  64};
    vecs[2] = '{4'd7,  1'b0, 8'h40, 8'h80, 128, 127};
    vecs[3] = '{4'd0,  1'b1, 8'h7F, 8'h80, 128, 128};
    vecs[4] = '{4'd15, 1'b0, 8'h7F, 8'h80, 128, 127};
    vecs[5] = '{4'd0,  1'b0, 8'h00, 8'hFF, 128, 127};
    vecs[6] = '{4'd2,  1'b0, 8'hE0, 8'h7F, 120, 159};
    vecs[7] = '{4'd0,  1'b0, 8'h81, 8'h7E,   1, 254};

    RESET_N      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    volume       = 4'd0;
    mute         = 1'b0;
    clr_underrun = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_pwm_out",      pwm_out,      0);
    check("rst_period_start", period_start, 0);
    check("rst_sample_ready", sample_ready, 0);
    check("rst_underrun",     underrun,     0);

    // Release with no samples: midscale output, underrun after first wrap.
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rel_sample_ready", sample_ready, 1);
    check("rel_period_start", period_start, 1);
    check("rel_pwm_out",      pwm_out,      3);
    check("rel_underrun",     underrun,     0);
    measure("idle", 128, 128);
    check("idle_underrun_set", underrun, 1);
    measure("idle2", 128, 128);

    // Table: stage at a period start, observe the following period.
    for (int v = 0; v < 8; v++) begin
      wait_ps(ok);
      volume = vecs[v].vol;
      mute   = vecs[v].mte;
      send(vecs[v].s0, vecs[v].s1);
      measure($sformatf("vec%0d", v), vecs[v].h0, vecs[v].h1);
    end
    volume = 4'd0;
    mute   = 1'b0;

    // Back-to-back frames: second waits for the boundary that loads the first.
    wait_ps(ok);
    sample_in    = 16'h807F;
    sample_valid = 1'b1;
    @(negedge CLK);
    check("b2b_ready_low", sample_ready, 0);
    sample_in = 16'h0000;
    lows = 1;
    for (int i = 0; i < 600 && sample_ready !== 1'b1; i++) begin
      @(negedge CLK);
      if (sample_ready !== 1'b1) lows++;
    end
    check("b2b_ready_low_cycles", lows, 254);
    check("b2b_ready_rise_ps",    period_start, 0);
    @(negedge CLK);
    check("b2b_second_ps",        period_start, 1);
    check("b2b_second_accepted",  sample_ready, 0);
    sample_valid = 1'b0;
    measure("b2b_first",  255, 0);
    measure("b2b_second", 128, 128);
    check("b2b_underrun", underrun, 1);

    // Clear on a starved wrap loses; clear elsewhere takes effect.
    wait_ps(ok);
    repeat (254) @(negedge CLK);
    clr_underrun = 1'b1;
    @(negedge CLK);
    clr_underrun = 1'b0;
    check("clr_on_wrap_kept", underrun, 1);
    repeat (5) @(negedge CLK);
    clr_underrun = 1'b1;
    @(negedge CLK);
    clr_underrun = 1'b0;
    check("clr_off_wrap", underrun, 0);

    // Mid-period reset with a staged frame discards it.
    wait_ps(ok);
    send(8'h7F, 8'h80);
    repeat (98) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("mid_rst_pwm_out",      pwm_out,      0);
    check("mid_rst_sample_ready", sample_ready, 0);
    check("mid_rst_period_start", period_start, 0);
    check("mid_rst_underrun",     underrun,     0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("mid_rel_ready", sample_ready, 1);
    check("mid_rel_ps",    period_start, 1);
    measure("mid_rel_p0", 128, 128);
    measure("mid_rel_p1", 128, 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_audio_stream_gen.md
PWM_AUDIO_STREAM_GEN -- requirements
Module: pwm_audio_stream_gen

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, meaning width of each two's-complement signed input sample (2..16).
REQ-002 SHALL have parameter PWM_W, default 8, meaning PWM counter width; one PWM period is 2^PWM_W clocks (4..12).
REQ-003 SHALL have parameter NUM_CH, default 2, meaning number of independent PWM output channels (1..8).
REQ-004 SHALL have port CLK  input  1  system clock; all logic updates on its rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port sample_in  input  NUM_CH*SAMPLE_W  signed samples; channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
REQ-007 SHALL have port sample_valid  input  1  sample_in holds a complete frame (all channels).
REQ-008 SHALL have port sample_ready  output  1  block can accept a frame this cycle.
REQ-009 SHALL have port volume  input  4  attenuation; arithmetic right-shift amount applied to each sample.
REQ-010 SHALL have port mute  input  1  force all channels to midscale.
REQ-011 SHALL have port clr_underrun  input  1  clear the underrun flag.
REQ-012 SHALL have port pwm_out  output  NUM_CH  per-channel PWM bit streams.
REQ-013 SHALL have port period_start  output  1  one-cycle pulse marking the first output cycle of each PWM period.
REQ-014 SHALL have port underrun  output  1  sticky flag: a period boundary passed with no new frame staged.

Function
REQ-015 SHALL run a free-running PWM_W-bit counter incrementing every cycle and wrapping from 2^PWM_W-1 to 0; "wrap cycle" = cycle with counter == 2^PWM_W-1.
REQ-016 SHALL hold a one-frame staging register with a full flag; sample_ready SHALL equal NOT full (registered, no combinational path from sample_valid).
REQ-017 SHALL capture sample_in into staging and set full when sample_valid AND sample_ready in a cycle.
REQ-018 SHALL, on a wrap cycle with full set, load the per-channel active duty registers from staging and clear full; sample_ready SHALL be high from the following cycle.
REQ-019 SHALL, on a wrap cycle with full clear, keep the active duty registers unchanged and set underrun.
REQ-020 SHALL, when a frame is accepted on a wrap cycle with full clear, place it in staging only (no bypass); it loads at the next wrap cycle and underrun is still set.
REQ-021 SHALL clear underrun on clr_underrun; simultaneous set and clear SHALL leave underrun = 1.
REQ-022 SHALL compute each duty as: s = sample >>> volume (sign-extending; shifts >= SAMPLE_W-1 yield 0 or -1); u = s with MSB inverted (offset binary, midscale 2^(SAMPLE_W-1)); then u << (PWM_W-SAMPLE_W) if PWM_W >= SAMPLE_W, else u >> (SAMPLE_W-PWM_W).
REQ-023 SHALL sample volume and mute at the wrap cycle only; mute = 1 at wrap loads duty 2^(PWM_W-1) for all channels regardless of staging, while staging/full/underrun behave per REQ-018..021.
REQ-024 SHALL register outputs: pwm_out[c] in cycle t+1 = (counter(t) < duty[c](t)); duty 0 gives constant low, maximum duty 2^PWM_W-1 gives high for all but one cycle per period.
REQ-025 SHALL assert period_start in exactly the cycle where pwm_out reflects counter == 0.
REQ-026 SHALL change duty only at period boundaries; no pwm_out glitch or truncated period within a period.

Reset
REQ-027 SHALL, while RESET_N = 0 at a clock edge, set counter = 0, full = 0, underrun = 0, all active duties = 2^(PWM_W-1), pwm_out = 0, period_start = 0, sample_ready = 0.
REQ-028 SHALL raise sample_ready on the first cycle after RESET_N returns high; reset asserted mid-period SHALL discard the staged frame and restart the period from counter 0.

Verification (defaults: SAMPLE_W=8, PWM_W=8, NUM_CH=2, period 256)
REQ-029 Release reset, no samples -> both pwm_out high 128 / low 128 cycles per period; underrun = 1 after first wrap; period_start every 256 cycles.
REQ-030 Frame ch0=0x7F, ch1=0x80, volume=0 -> from next period ch0 high 255 cycles, ch1 high 0 cycles.
REQ-031 Two back-to-back valid frames -> first accepted, sample_ready low until the wrap cycle loads it, high next cycle, second frame accepted then.
REQ-032 ch0=0x40 volume=1 -> duty 0xA0 (high 160); ch1=0x80 volume=7 -> s = -1 -> duty 0x7F (high 127); mute=1 at next wrap -> both 128.
REQ-033 underrun = 1 with clr_underrun pulsed on a starved wrap cycle -> underrun stays 1; pulse on a non-wrap cycle -> 0 next cycle.
REQ-034 RESET_N low one cycle at counter = 100 with frame staged -> next cycle pwm_out = 0, sample_ready = 0, full = 0; after release, period restarts at midscale duty.
